// File: rtl/axis_pixel_unpacker.sv
// rtl/axis_pixel_unpacker.sv - unpacks 3 x 32-bit stream words into 4 RGB888 pixels
// with screen coordinates, and flags tuser/tlast/tkeep framing errors.
module axis_pixel_unpacker #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int COLOR_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            in_stream_tdata,
  input  logic [3:0]             in_stream_tkeep,
  input  logic                   in_stream_tlast,
  input  logic                   in_stream_tuser,
  input  logic                   in_stream_tvalid,
  output logic                   in_stream_tready,
  output logic [COLOR_WIDTH-1:0] pix_r,
  output logic [COLOR_WIDTH-1:0] pix_g,
  output logic [COLOR_WIDTH-1:0] pix_b,
  output logic [9:0]             pix_x,
  output logic [8:0]             pix_y,
  output logic                   pix_sof,
  output logic                   pix_eol,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  input  logic                   clear_err,
  output logic                   err_sof,
  output logic                   err_eol,
  output logic                   err_keep
);

  localparam int         WPL     = SCREEN_WIDTH * 3 / 4;
  localparam logic [9:0] X_LAST  = 10'(SCREEN_WIDTH - 1);
  localparam logic [8:0] Y_LAST  = 9'(SCREEN_HEIGHT - 1);
  localparam logic [9:0] WC_LAST = 10'(WPL - 1);

  typedef enum logic [2:0] {SYNC, W0, W1, W2, W2B} state_t;

  state_t      state;
  logic [15:0] carry;
  logic [23:0] p3;
  logic [9:0]  nx;
  logic [8:0]  ny;
  logic [9:0]  wc;
  logic        restart_pend;

  logic        out_fire, in_fire, load_in, at_end, early, restart;
  state_t      phase;
  logic [9:0]  cur_x, wc_eff, nx_n;
  logic [8:0]  cur_y, ny_n;
  logic [23:0] new_px, ld_px;
  logic [9:0]  ld_x;
  logic [8:0]  ld_y;
  logic        ld_en;
  logic        sof_bad, eol_bad, keep_bad;

  function automatic logic [8:0] y_next(input logic [8:0] y);
    return (y == Y_LAST) ? 9'd0 : y + 9'd1;
  endfunction

  assign in_stream_tready = !rst && (state == SYNC ||
                            (state != W2B && (!pix_valid || pix_ready)));
  assign out_fire = pix_valid & pix_ready;
  assign in_fire  = in_stream_tvalid & in_stream_tready;
  // In SYNC only a tuser word is decoded; everything else is dropped.
  assign load_in  = in_fire & (state != SYNC || in_stream_tuser);

  assign sof_bad  = load_in & in_stream_tuser & (state != SYNC) &
                    !(state == W0 && wc == 10'd0 && ny == 9'd0);
  assign eol_bad  = load_in & (in_stream_tlast != at_end);
  assign keep_bad = in_fire & (in_stream_tkeep != 4'hF);

  always_comb begin
    // A tuser word always restarts decoding as w0 of a fresh frame.
    phase  = in_stream_tuser ? W0 : state;
    cur_x  = in_stream_tuser ? 10'd0 : nx;
    cur_y  = in_stream_tuser ? 9'd0 : ny;
    wc_eff = in_stream_tuser ? 10'd0 : wc;
    at_end = (wc_eff == WC_LAST);
    early  = in_stream_tlast & !at_end;
    case (phase)
      W1:      new_px = {in_stream_tdata[15:0], carry[7:0]};
      W2:      new_px = {in_stream_tdata[7:0], carry};
      default: new_px = in_stream_tdata[23:0];
    endcase

    ld_en   = 1'b0;
    ld_px   = new_px;
    ld_x    = cur_x;
    ld_y    = cur_y;
    restart = 1'b0;
    if (load_in) begin
      ld_en   = 1'b1;
      restart = early && phase != W2;
    end else if (state == W2B && out_fire) begin
      ld_en   = 1'b1;
      ld_px   = p3;
      ld_x    = nx;
      ld_y    = ny;
      restart = restart_pend;
    end

    if (restart || ld_x == X_LAST) begin
      nx_n = 10'd0;
      ny_n = y_next(ld_y);
    end else begin
      nx_n = ld_x + 10'd1;
      ny_n = ld_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SYNC;
      carry        <= '0;
      p3           <= '0;
      nx           <= '0;
      ny           <= '0;
      wc           <= '0;
      restart_pend <= 1'b0;
      pix_r        <= '0;
      pix_g        <= '0;
      pix_b        <= '0;
      pix_x        <= '0;
      pix_y        <= '0;
      pix_sof      <= 1'b0;
      pix_eol      <= 1'b0;
      pix_valid    <= 1'b0;
      err_sof      <= 1'b0;
      err_eol      <= 1'b0;
      err_keep     <= 1'b0;
    end else begin
      err_sof  <= (err_sof & ~clear_err) | sof_bad;
      err_eol  <= (err_eol & ~clear_err) | eol_bad;
      err_keep <= (err_keep & ~clear_err) | keep_bad;

      if (out_fire) pix_valid <= 1'b0;
      if (ld_en) begin
        pix_valid <= 1'b1;
        pix_r     <= ld_px[23:16];
        pix_g     <= ld_px[15:8];
        pix_b     <= ld_px[7:0];
        pix_x     <= ld_x;
        pix_y     <= ld_y;
        pix_sof   <= (ld_x == 10'd0 && ld_y == 9'd0);
        pix_eol   <= (ld_x == X_LAST);
        nx        <= nx_n;
        ny        <= ny_n;
      end

      if (load_in) begin
        wc           <= (early || at_end) ? 10'd0 : wc_eff + 10'd1;
        restart_pend <= early;
        case (phase)
          W0: begin
            carry <= {8'h00, in_stream_tdata[31:24]};
            state <= early ? W0 : W1;
          end
          W1: begin
            carry <= in_stream_tdata[31:16];
            state <= early ? W0 : W2;
          end
          default: begin
            p3    <= in_stream_tdata[31:8];
            state <= W2B;
          end
        endcase
      end else if (state == W2B && out_fire) begin
        state <= W0;
      end
    end
  end

endmodule

// File: tb/tb_axis_pixel_unpacker.sv
// tb/tb_axis_pixel_unpacker.sv - directed bench for axis_pixel_unpacker on a reduced
// 32x6 screen: byte order, framing errors, backpressure and reset.
module tb_axis_pixel_unpacker;

  localparam int W   = 32;
  localparam int H   = 6;
  localparam int WPL = W * 3 / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_stream_tdata = '0;
  logic [3:0]  in_stream_tkeep = 4'hF;
  logic        in_stream_tlast = 1'b0;
  logic        in_stream_tuser = 1'b0;
  logic        in_stream_tvalid = 1'b0;
  logic        in_stream_tready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_sof, pix_eol, pix_valid;
  logic        pix_ready = 1'b0;
  logic        clear_err = 1'b0;
  logic        err_sof, err_eol, err_keep;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          rdy_mode = 1;
  logic [44:0] q[$];

  axis_pixel_unpacker #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .COLOR_WIDTH  (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_stream_tdata (in_stream_tdata),
    .in_stream_tkeep (in_stream_tkeep),
    .in_stream_tlast (in_stream_tlast),
    .in_stream_tuser (in_stream_tuser),
    .in_stream_tvalid(in_stream_tvalid),
    .in_stream_tready(in_stream_tready),
    .pix_r           (pix_r),
    .pix_g           (pix_g),
    .pix_b           (pix_b),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_sof         (pix_sof),
    .pix_eol         (pix_eol),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .clear_err       (clear_err),
    .err_sof         (err_sof),
    .err_eol         (err_eol),
    .err_keep        (err_keep)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       pix_ready = 1'b0;
      1:       pix_ready = 1'b1;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk)
    if (!rst && pix_valid && pix_ready)
      q.push_back({pix_x, pix_y, pix_sof, pix_eol, pix_r, pix_g, pix_b});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [44:0] mk(input int x, input int y, input logic [23:0] px);
    return {10'(x), 9'(y), 1'(x == 0 && y == 0), 1'(x == W - 1), px};
  endfunction

  function automatic logic [7:0] pat(input int i, input int mul);
    return 8'(i * mul + mul);
  endfunction

  function automatic logic [31:0] wd(input int n, input int mul);
    return {pat(4 * n + 3, mul), pat(4 * n + 2, mul), pat(4 * n + 1, mul), pat(4 * n, mul)};
  endfunction

  function automatic logic [23:0] px_at(input int k, input int mul);
    return {pat(3 * k + 2, mul), pat(3 * k + 1, mul), pat(3 * k, mul)};
  endfunction

  task automatic send(input logic [31:0] d, input logic u, input logic l, input logic [3:0] k);
    int   t;
    logic acc;
    in_stream_tdata  = d;
    in_stream_tuser  = u;
    in_stream_tlast  = l;
    in_stream_tkeep  = k;
    in_stream_tvalid = 1'b1;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_stream_tready;
      t++;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    @(posedge clk);
    #1;
    in_stream_tvalid = 1'b0;
  endtask

  task automatic send_lines(input int nwords, input int mul);
    for (int n = 0; n < nwords; n++)
      send(wd(n, mul), n == 0, (n % WPL) == WPL - 1, 4'hF);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_stream_tvalid = 1'b0;
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic wait_q(input int n);
    for (int i = 0; i < 3000 && q.size() < n; i++) @(negedge clk);
    #1;
  endtask

  task automatic check_seq(input int n, input int mul, input string tag);
    int bad;
    bad = 0;
    chk({tag, "_count"}, 64'(q.size()), 64'(n));
    for (int k = 0; k < n && k < q.size(); k++)
      if (q[k] !== mk(k % W, (k / W) % H, px_at(k, mul))) bad++;
    chk({tag, "_seq_bad"}, 64'(bad), 64'd0);
  endtask

  initial begin
    // Reset state
    rdy_mode = 1;
    do_reset();
    @(negedge clk);
    chk("rst_pix_valid", 64'(pix_valid), 64'd0);
    chk("rst_tready", 64'(in_stream_tready), 64'd1);
    chk("rst_errs", 64'({err_sof, err_eol, err_keep}), 64'd0);
    chk("rst_xy", 64'({pix_x, pix_y}), 64'd0);
    chk("rst_rgb", 64'({pix_r, pix_g, pix_b}), 64'd0);

    // Byte order of one three-word group
    @(posedge clk);
    #1;
    send(32'h11223344, 1'b1, 1'b0, 4'hF);
    send(32'h55667788, 1'b0, 1'b0, 4'hF);
    send(32'h99AABBCC, 1'b0, 1'b0, 4'hF);
    @(negedge clk);
    chk("w2b_tready_low", 64'(in_stream_tready), 64'd0);
    @(negedge clk);
    chk("after_w2b_tready", 64'(in_stream_tready), 64'd1);
    @(posedge clk);
    #1;
    chk("grp_count", 64'(q.size()), 64'd4);
    chk("grp_p0", 64'(q[0]), 64'(mk(0, 0, 24'h223344)));
    chk("grp_p1", 64'(q[1]), 64'(mk(1, 0, 24'h778811)));
    chk("grp_p2", 64'(q[2]), 64'(mk(2, 0, 24'hCC5566)));
    chk("grp_p3", 64'(q[3]), 64'(mk(3, 0, 24'h99AABB)));

    // Full frame, incrementing bytes
    do_reset();
    send_lines(WPL * H, 1);
    wait_q(W * H);
    check_seq(W * H, 1, "frame");
    chk("frame_last", 64'(q[W * H - 1]), 64'(mk(W - 1, H - 1, px_at(W * H - 1, 1))));
    chk("frame_errs", 64'({err_sof, err_eol, err_keep}), 64'd0);

    // Early tlast on wc=10 of line 0, then bad tkeep, then clear_err
    do_reset();
    for (int n = 0; n <= 10; n++) send(wd(n, 5), n == 0, n == 10, 4'hF);
    chk("early_eol_flag", 64'(err_eol), 64'd1);
    send(32'hDEADBEEF, 1'b0, 1'b0, 4'h3);
    wait_q(15);
    chk("early_count", 64'(q.size()), 64'd15);
    chk("early_last_of_line", 64'(q[13]), 64'(mk(13, 0, px_at(13, 5))));
    chk("early_next_line", 64'(q[14]), 64'(mk(0, 1, 24'hADBEEF)));
    chk("keep_flag", 64'(err_keep), 64'd1);
    clear_err = 1'b1;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
    chk("clear_eol", 64'(err_eol), 64'd0);
    chk("clear_keep", 64'(err_keep), 64'd0);
    clear_err = 1'b1;
    send(32'h0BADF00D, 1'b0, 1'b0, 4'h0);
    clear_err = 1'b0;
    chk("keep_beats_clear", 64'(err_keep), 64'd1);
    chk("no_eol_midline", 64'(err_eol), 64'd0);

    // tuser on wc=5 of line 2
    do_reset();
    send_lines(2 * WPL + 5, 3);
    send(32'h00C0FFEE, 1'b1, 1'b0, 4'hF);
    send(32'h12345678, 1'b0, 1'b0, 4'hF);
    wait_q(72);
    chk("sof_count", 64'(q.size()), 64'd72);
    chk("sof_held_pixel", 64'(q[69]), 64'(mk(5, 2, px_at(69, 3))));
    chk("sof_restart_p0", 64'(q[70]), 64'(mk(0, 0, 24'hC0FFEE)));
    chk("sof_restart_p1", 64'(q[71]), 64'(mk(1, 0, 24'h567800)));
    chk("sof_flag", 64'({err_sof, err_eol}), 64'b10);

    // Random backpressure over two lines, then reset mid-line
    do_reset();
    rdy_mode = 2;
    send_lines(2 * WPL, 9);
    wait_q(2 * W);
    check_seq(2 * W, 9, "rand");
    chk("rand_errs", 64'({err_sof, err_eol, err_keep}), 64'd0);
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(32'h55AA55AA, 1'b0, 1'b0, 4'hF);
    repeat (2) @(negedge clk);
    chk("stall_valid_held", 64'(pix_valid), 64'd1);
    chk("stall_tready_low", 64'(in_stream_tready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midline_rst_valid", 64'(pix_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    rdy_mode = 1;
    send(32'h01020304, 1'b0, 1'b0, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    chk("sync_discard_count", 64'(q.size()), 64'd0);
    chk("sync_discard_valid", 64'(pix_valid), 64'd0);
    send(32'hA0B0C0D0, 1'b1, 1'b0, 4'hF);
    wait_q(1);
    chk("sync_first_pixel", 64'(q[0]), 64'(mk(0, 0, 24'hB0C0D0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
